// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the data-bus bridge: I/O register addresses, digit count
// and the hex-to-7-segment table (active-low, {dp,g,f,e,d,c,b,a}).
package mem_io_bridge_pkg;
  localparam logic [31:0] SEG_ADDR = 32'hFFFF_F000;
  localparam logic [31:0] LED_ADDR = 32'hFFFF_F060;
  localparam logic [31:0] SW_ADDR  = 32'hFFFF_F070;
  localparam logic [31:0] BTN_ADDR = 32'hFFFF_F078;

  localparam int DIG_COUNT = 8;

  // Index 0 is the rightmost entry; dp (bit 7) is always off.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction
endpackage

// File: rtl/mem_io_bridge_seg7_scan.sv
// Multiplexed 7-segment scanner: steps one digit every SCAN_DIV clocks and
// registers the segment pattern alongside the digit enable.
module seg7_scan
  import mem_io_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_value,
  output logic [7:0]  o_seg_n,
  output logic [7:0]  o_dig_en_n
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIG_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [7:0]           r_seg_n;
  logic [DIG_COUNT-1:0] r_dig_en_n;
  logic                 w_wrap;
  logic [IW-1:0]        w_idx_nxt;

  assign w_wrap    = (r_cnt == CNT_MAX);
  assign w_idx_nxt = r_idx + IW'(1);

  // seg_n only reloads on the digit change, so a SEG write mid-digit waits for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_seg_n    <= 8'hC0;
      r_dig_en_n <= 8'hFE;
    end else if (w_wrap) begin
      r_cnt      <= '0;
      r_idx      <= w_idx_nxt;
      r_seg_n    <= hex2seg(i_value[{w_idx_nxt, 2'b00} +: 4]);
      r_dig_en_n <= ~(DIG_COUNT'(1) << w_idx_nxt);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_seg_n    = r_seg_n;
  assign o_dig_en_n = r_dig_en_n;
endmodule

// File: rtl/mem_io_bridge.sv
// Data-bus responder for the single-cycle core: asynchronous-read data RAM plus
// memory-mapped SEG/LED/switch/button registers and the display scanner.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int          DRAM_AW  = 14,
  parameter int          SCAN_DIV = 20000,
  parameter logic [31:0] IO_BASE  = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [23:0] sw_i,
  input  logic [4:0]  btn_i,
  output logic [23:0] led_o,
  output logic [7:0]  seg_n,
  output logic [7:0]  dig_en_n
);
  logic [31:0]        r_dram [2**DRAM_AW];
  logic [31:0]        r_seg;
  logic [23:0]        r_led;
  logic [23:0]        r_sw_s1, r_sw_s2;
  logic [4:0]         r_btn_s1, r_btn_s2;
  logic               w_is_io;
  logic [31:0]        w_word;
  logic [DRAM_AW-1:0] w_widx;

  assign w_is_io = (bus_addr >= IO_BASE);
  assign w_word  = {bus_addr[31:2], 2'b00};
  assign w_widx  = bus_addr[DRAM_AW+1:2];

  always_ff @(posedge clk) begin
    if (bus_we && !w_is_io) r_dram[w_widx] <= bus_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= '0;
      r_led    <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw_i;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn_i;
      r_btn_s2 <= r_btn_s1;
      if (bus_we && w_is_io) begin
        if (w_word == SEG_ADDR) r_seg <= bus_wdata;
        if (w_word == LED_ADDR) r_led <= bus_wdata[23:0];
      end
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (!w_is_io) begin
      bus_rdata = r_dram[w_widx];
    end else begin
      case (w_word)
        SEG_ADDR: bus_rdata = r_seg;
        LED_ADDR: bus_rdata = {8'h00, r_led};
        SW_ADDR:  bus_rdata = {8'h00, r_sw_s2};
        BTN_ADDR: bus_rdata = {27'h0, r_btn_s2};
        default:  bus_rdata = '0;
      endcase
    end
  end

  assign led_o = r_led;

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_value    (r_seg),
    .o_seg_n    (seg_n),
    .o_dig_en_n (dig_en_n)
  );
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: a cycle-count based model checked on every falling
// edge, plus directed vectors with hand-computed expectations.
module tb_mem_io_bridge;
  localparam int          SD  = 4;
  localparam logic [31:0] IOB = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        bus_we = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [23:0] sw_i = '0;
  logic [4:0]  btn_i = '0;
  logic [23:0] led_o;
  logic [7:0]  seg_n;
  logic [7:0]  dig_en_n;

  int checks = 0;
  int failures = 0;

  mem_io_bridge #(.DRAM_AW(14), .SCAN_DIV(SD), .IO_BASE(IOB)) dut (
    .clk(clk), .rst_n(rst_n), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .sw_i(sw_i), .btn_i(btn_i),
    .led_o(led_o), .seg_n(seg_n), .dig_en_n(dig_en_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: display state derived from clocks elapsed since reset.
  logic [7:0]  lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  bit   [31:0] m_dram [int];
  logic [31:0] m_seg = '0;
  logic [23:0] m_led = '0, m_sw1 = '0, m_sw2 = '0;
  logic [4:0]  m_b1 = '0, m_b2 = '0;
  int          m_cyc = 0;
  logic [7:0]  m_segn = 8'hC0;

  function automatic int m_dig();
    return (m_cyc / SD) % 8;
  endfunction

  function automatic bit m_known(input logic [31:0] a);
    return (a >= IOB) || m_dram.exists(int'(a[15:2]));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < IOB) return m_dram[int'(a[15:2])];
    case ({a[31:2], 2'b00})
      32'hFFFF_F000: return m_seg;
      32'hFFFF_F060: return {8'h0, m_led};
      32'hFFFF_F070: return {8'h0, m_sw2};
      32'hFFFF_F078: return {27'h0, m_b2};
      default:       return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_seg = '0; m_led = '0; m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
      m_cyc = 0; m_segn = 8'hC0;
    end else begin
      m_cyc++;
      if (m_cyc % SD == 0) m_segn = lut[(m_seg >> (4 * m_dig())) & 32'hF];
      m_sw2 = m_sw1; m_sw1 = sw_i;
      m_b2 = m_b1;   m_b1 = btn_i;
      if (bus_we) begin
        if (bus_addr < IOB) m_dram[int'(bus_addr[15:2])] = bus_wdata;
        else if ({bus_addr[31:2], 2'b00} == 32'hFFFF_F000) m_seg = bus_wdata;
        else if ({bus_addr[31:2], 2'b00} == 32'hFFFF_F060) m_led = bus_wdata[23:0];
      end
    end
  end

  always @(negedge clk) begin
    check("m_led", {8'h0, led_o}, {8'h0, m_led});
    check("m_dig_en", {24'h0, dig_en_n}, {24'h0, ~(8'h01 << m_dig())});
    check("m_seg_n", {24'h0, seg_n}, {24'h0, m_segn});
    if (m_known(bus_addr)) check("m_rdata", bus_rdata, m_read(bus_addr));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    step();
    bus_we = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus_we = 1'b0; bus_addr = a;
    #1;
    check(nm, bus_rdata, exp);
  endtask

  task automatic wait_fresh(input string nm, input logic [7:0] tgt);
    logic [7:0] prev;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      prev = dig_en_n;
      step();
      if (prev != tgt && dig_en_n == tgt) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, {31'h0, ok}, 32'h1);
  endtask

  logic [7:0] seg_exp [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    check("rst_dig_en", {24'h0, dig_en_n}, 32'hFE);
    check("rst_seg_n", {24'h0, seg_n}, 32'hC0);
    check("rst_led", {8'h0, led_o}, 32'h0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;

    // DRAM round-trip and aliasing
    wr(32'h0000_0014, 32'hDEAD_BEEF);
    wr(32'h0000_0010, 32'h1234_5678);
    rd("dram_10", 32'h0000_0010, 32'h1234_5678);
    rd("dram_14", 32'h0000_0014, 32'hDEAD_BEEF);
    rd("dram_alias", 32'h0004_0010, 32'h1234_5678);

    // LED register
    wr(32'hFFFF_F060, 32'hABCD_EF01);
    check("led_write", {8'h0, led_o}, 32'h00CD_EF01);
    rd("led_read", 32'hFFFF_F060, 32'h00CD_EF01);
    wr(32'hFFFF_F064, 32'h1111_1111);
    check("led_hole_wr", {8'h0, led_o}, 32'h00CD_EF01);
    rd("io_hole_rd", 32'hFFFF_F064, 32'h0);

    // Synchronisers
    @(negedge clk);
    sw_i = 24'h00_00A5; btn_i = 5'h15; bus_addr = 32'hFFFF_F070;
    step();
    check("sw_edge1", bus_rdata, 32'h0);
    step();
    check("sw_edge2", bus_rdata, 32'h0000_00A5);
    rd("btn_sync", 32'hFFFF_F078, 32'h0000_0015);
    wr(32'hFFFF_F070, 32'hFFFF_FFFF);
    rd("sw_ro", 32'hFFFF_F070, 32'h0000_00A5);

    // Full scan of SEG=0x76543210
    wr(32'hFFFF_F000, 32'h7654_3210);
    rd("seg_read", 32'hFFFF_F000, 32'h7654_3210);
    wait_fresh("scan_sync", 8'hFE);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("scan_en_%0d", i), {24'h0, dig_en_n}, {24'h0, ~(8'h01 << (i / 4))});
      check($sformatf("scan_seg_%0d", i), {24'h0, seg_n}, {24'h0, seg_exp[i / 4]});
      step();
    end
    check("scan_wrap", {24'h0, dig_en_n}, 32'hFE);

    // SEG update while digit 3 is showing
    wait_fresh("mid_sync3", 8'hF7);
    wr(32'hFFFF_F000, 32'hFFFF_FFFF);
    check("mid_seg_hold", {24'h0, seg_n}, 32'hB0);
    wait_fresh("mid_sync4", 8'hEF);
    check("mid_seg_8e", {24'h0, seg_n}, 32'h8E);
    n = 0;
    while (dig_en_n == 8'hEF && n < 10) begin
      n++;
      step();
    end
    check("mid_period", n, 32'd4);

    // Asynchronous reset at digit 5
    wait_fresh("rst_sync5", 8'hDF);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_dig_en", {24'h0, dig_en_n}, 32'hFE);
    check("arst_seg_n", {24'h0, seg_n}, 32'hC0);
    check("arst_led", {8'h0, led_o}, 32'h0);
    step(); step();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("post_rst_%0d", i), {24'h0, dig_en_n}, (i < 4) ? 32'hFE : 32'hFD);
    end
    rd("dram_keep", 32'h0000_0010, 32'h1234_5678);
    rd("seg_cleared", 32'hFFFF_F000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
